// File: rtl/trng_reader.sv
// rtl/trng_reader.sv - TRNG consumer: decimate, RCT health test, von Neumann debias, pack, FWFT FIFO
//
// Purpose: samples the ring generator's serial bit every DECIM enabled cycles,
// runs a repetition-count health test on raw samples, debiases sample pairs,
// packs debiased bits LSB-first into OUT_W-bit words and buffers them in a
// first-word-fall-through FIFO.
//
// Ports:
//   i_clk       clock
//   i_rst       asynchronous active-high reset
//   i_en        sampling enable (decimation counter held at 0 while low)
//   i_clr       synchronous clear of all state, highest priority
//   i_bit       serial entropy bit
//   i_ready     downstream ready
//   o_valid     FIFO not empty
//   o_data      FIFO head word (holds last head when empty)
//   o_level     FIFO occupancy
//   o_rct_fail  sticky repetition-count failure
module trng_reader #(
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DECIM      = 4,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_clr,
  input  logic                         i_bit,
  input  logic                         i_ready,
  output logic                         o_valid,
  output logic [OUT_W-1:0]             o_data,
  output logic [$clog2(FIFO_DEPTH):0]  o_level,
  output logic                         o_rct_fail
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = $clog2(OUT_W);
  localparam logic [7:0]      DC_LAST  = 8'(DECIM - 1);
  localparam logic [7:0]      RC_MAX   = 8'(RCT_CUTOFF);
  localparam logic [CW-1:0]   CNT_LAST = CW'(OUT_W - 1);
  localparam logic [AW:0]     LVL_FULL = {1'b1, {AW{1'b0}}};

  logic [7:0]       r_dc;
  logic             r_s;
  logic             r_seen;
  logic [7:0]       r_rc;
  logic             r_fail;
  logic             r_phase;
  logic             r_a;
  logic [OUT_W-1:0] r_word;
  logic [CW-1:0]    r_cnt;
  logic             r_full;
  logic [OUT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_level;
  logic [OUT_W-1:0] r_hold;

  logic             w_strobe;
  logic [7:0]       w_rc_next;
  logic             w_fail_set;
  logic             w_fail;
  logic             w_db_valid;
  logic             w_pop;
  logic             w_push;

  always_comb begin
    w_strobe = i_en && (r_dc == DC_LAST);
    w_rc_next = 8'd1;
    if (r_seen && (i_bit == r_s)) begin
      w_rc_next = (r_rc == RC_MAX) ? RC_MAX : r_rc + 8'd1;
    end
    w_fail_set = w_strobe && (w_rc_next == RC_MAX);
    // Flush/clear takes effect on the same edge the flag sets.
    w_fail     = r_fail || w_fail_set;
    // Second sample of a pair that differs from the first yields bit r_a.
    w_db_valid = w_strobe && r_phase && (i_bit != r_a);
    w_pop      = (r_level != '0) && i_ready;
    w_push     = r_full && !w_fail && ((r_level != LVL_FULL) || w_pop);
  end

  assign o_valid    = (r_level != '0);
  assign o_data     = o_valid ? r_mem[r_rp] : r_hold;
  assign o_level    = r_level;
  assign o_rct_fail = r_fail;

  // Decimation and repetition-count test.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dc   <= '0;
      r_s    <= 1'b0;
      r_seen <= 1'b0;
      r_rc   <= '0;
      r_fail <= 1'b0;
    end else if (i_clr) begin
      r_dc   <= '0;
      r_s    <= 1'b0;
      r_seen <= 1'b0;
      r_rc   <= '0;
      r_fail <= 1'b0;
    end else begin
      if (!i_en || w_strobe) begin
        r_dc <= '0;
      end else begin
        r_dc <= r_dc + 8'd1;
      end
      if (w_strobe) begin
        r_s    <= i_bit;
        r_seen <= 1'b1;
        r_rc   <= w_rc_next;
      end
      if (w_fail_set) begin
        r_fail <= 1'b1;
      end
    end
  end

  // Pairing and packer. A complete word sits in r_word until it can be pushed;
  // debiased bits arriving meanwhile are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= 1'b0;
      r_a     <= 1'b0;
      r_word  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
    end else if (i_clr || w_fail) begin
      r_phase <= 1'b0;
      r_a     <= 1'b0;
      r_word  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_strobe) begin
        r_phase <= !r_phase;
        if (!r_phase) begin
          r_a <= i_bit;
        end
      end
      if (w_push) begin
        r_full <= 1'b0;
      end
      if (w_db_valid && !r_full) begin
        r_word[r_cnt] <= r_a;
        if (r_cnt == CNT_LAST) begin
          r_cnt  <= '0;
          r_full <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // FIFO storage and pointers; r_hold keeps the last head for the empty case.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_hold  <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_hold  <= '0;
    end else if (w_fail) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (o_valid) begin
        r_hold <= r_mem[r_rp];
      end
      if (w_push) begin
        r_mem[r_wp] <= r_word;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_reader.sv
// tb/tb_trng_reader.sv - scoreboard bench for trng_reader
module tb_trng_reader;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_en = 1'b0, i_clr = 1'b0, i_bit = 1'b0, i_ready = 1'b0;
  logic       o_valid;
  logic [7:0] o_data;
  logic [2:0] o_level;
  logic       o_rct_fail;

  logic       en4 = 1'b0, clr4 = 1'b0, bit4 = 1'b0, ready4 = 1'b0;
  logic       valid4;
  logic [7:0] data4;
  logic [2:0] level4;
  logic       fail4;

  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  trng_reader #(.OUT_W(8), .FIFO_DEPTH(4), .DECIM(1), .RCT_CUTOFF(32)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_clr(i_clr), .i_bit(i_bit),
    .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data), .o_level(o_level),
    .o_rct_fail(o_rct_fail)
  );

  trng_reader #(.OUT_W(8), .FIFO_DEPTH(4), .DECIM(4), .RCT_CUTOFF(32)) u_dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(en4), .i_clr(clr4), .i_bit(bit4),
    .i_ready(ready4), .o_valid(valid4), .o_data(data4), .o_level(level4),
    .o_rct_fail(fail4)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic send_bit(input logic b);
    i_en  = 1'b1;
    i_bit = b;
    tick();
    i_en  = 1'b0;
  endtask

  // Each pair (x, !x) yields exactly one debiased bit x.
  task automatic send_word(input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      send_bit(w[k]);
      send_bit(!w[k]);
    end
  endtask

  task automatic do_clr();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    int         got;
    logic [7:0] e;
    got = 0;
    i_ready = 1'b1;
    for (int c = 0; c < n * 40 + 20 && got < n; c++) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra"}, 32'(o_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_data"}, 32'(o_data), 32'(e));
        end
        got++;
      end
      tick();
    end
    i_ready = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(n));
    check({tag, "_empty"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    int         pat [20] = '{0,1, 1,0, 0,0, 1,1, 0,1, 0,1, 1,0, 1,0, 0,1, 1,0};

    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data",  32'(o_data),  32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_fail",  32'(o_rct_fail), 32'd0);
    check("rst_level4", 32'(level4), 32'd0);

    // Test 1: "10" pairs -> two 0xFF words, push latency.
    for (int i = 0; i < 32; i++) begin
      send_bit((i % 2) == 0);
      if (i == 15) check("t1_valid_before_push", 32'(o_valid), 32'd0);
      if (i == 16) check("t1_valid_after_push", 32'(o_valid), 32'd1);
    end
    tick();
    check("t1_level", 32'(o_level), 32'd2);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    drain("t1", 2);

    // Test 2: mixed pairs, equal pairs discarded.
    do_clr();
    for (int i = 0; i < 20; i++) send_bit(pat[i][0]);
    tick();
    check("t2_level", 32'(o_level), 32'd1);
    exp_q.push_back(8'hB2);
    drain("t2", 1);

    // Test 3: repetition-count failure flushes FIFO, clear recovers.
    do_clr();
    send_word(8'($urandom) | 8'h80);
    send_word(8'($urandom) | 8'h80);
    tick();
    check("t3_preload", 32'(o_level), 32'd2);
    for (int i = 0; i < 31; i++) send_bit(1'b1);
    check("t3_fail_31", 32'(o_rct_fail), 32'd0);
    check("t3_level_31", 32'(o_level), 32'd2);
    send_bit(1'b1);
    check("t3_fail_32", 32'(o_rct_fail), 32'd1);
    check("t3_flush_level", 32'(o_level), 32'd0);
    check("t3_flush_valid", 32'(o_valid), 32'd0);
    send_word(8'($urandom));
    tick();
    check("t3_no_push", 32'(o_level), 32'd0);
    check("t3_sticky", 32'(o_rct_fail), 32'd1);
    do_clr();
    check("t3_clr_fail", 32'(o_rct_fail), 32'd0);
    w = 8'($urandom);
    send_word(w);
    exp_q.push_back(w);
    drain("t3", 1);

    // Test 4: full FIFO, held word, dropped bits, pop+push same cycle.
    do_clr();
    for (int i = 0; i < 5; i++) begin
      w = 8'($urandom);
      send_word(w);
      exp_q.push_back(w);
    end
    tick();
    check("t4_full", 32'(o_level), 32'd4);
    send_word(8'($urandom));
    check("t4_drop_level", 32'(o_level), 32'd4);
    i_ready = 1'b1;
    w = exp_q.pop_front();
    check("t4_head", 32'(o_data), 32'(w));
    tick();
    i_ready = 1'b0;
    check("t4_level_kept", 32'(o_level), 32'd4);
    w = 8'($urandom);
    send_word(w);
    exp_q.push_back(w);
    drain("t4", 5);

    // Test 5: DECIM=4 instance, enable gap mid-count.
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    en4 = 1'b1;
    bit4 = 1'b1;
    tick();
    tick();
    en4 = 1'b0;
    repeat (3) tick();
    w = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      for (int h = 0; h < 2; h++) begin
        for (int c = 0; c < 4; c++) begin
          en4  = 1'b1;
          bit4 = (c == 3) ? (w[k] ^ (h == 1)) : !(w[k] ^ (h == 1));
          tick();
        end
      end
    end
    en4 = 1'b0;
    tick();
    check("t5_level", 32'(level4), 32'd1);
    check("t5_valid", 32'(valid4), 32'd1);
    check("t5_data", 32'(data4), 32'(w));

    // Test 6: asynchronous reset mid-word.
    do_clr();
    for (int i = 0; i < 3; i++) send_word(8'($urandom));
    tick();
    check("t6_level3", 32'(o_level), 32'd3);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      send_bit(1'b0);
    end
    #2 i_rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(o_valid), 32'd0);
    check("t6_rst_level", 32'(o_level), 32'd0);
    check("t6_rst_fail", 32'(o_rct_fail), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    w = 8'($urandom) & 8'h7F;
    send_word(w);
    exp_q.push_back(w);
    drain("t6", 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/trng_reader.md
Name: trng_reader

Overview:
- Consumer end of the ring-generator entropy path.
- Samples the serial output bit (`o_pulse`) of the 32-bit ring generator at a decimated rate.
- Runs a repetition-count health test on raw samples, von Neumann-debiases them, and packs the result into OUT_W-bit words.
- Delivers words through a small first-word-fall-through FIFO with a valid/ready handshake to the system-side reader.

Parameters:
- OUT_W, 8, width of each output word in debiased bits (2..32).
- FIFO_DEPTH, 4, number of output words buffered (power of two, ≥2).
- DECIM, 4, sample i_bit once every DECIM enabled cycles (1..255).
- RCT_CUTOFF, 32, consecutive identical raw samples that trip the health failure (2..255).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset: asynchronous, active-high; clock i_clk.
- i_en  input  1  sampling enable; when low, the decimation counter holds at 0 and no samples are taken.
- i_clr  input  1  synchronous clear of all datapath state and the fail flag; same effect as reset except it is synchronous.
- i_bit  input  1  serial entropy bit from the ring generator.
- i_ready  input  1  downstream ready.
- o_valid  output  1  FIFO not empty.
- o_data  output  OUT_W  FIFO head word.
- o_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_rct_fail  output  1  sticky health-test failure.

Behaviour:
- Reset / i_clr: every register goes to 0, so o_valid=0, o_data=0, o_level=0, o_rct_fail=0. i_clr has priority over every other same-cycle event.

Decimation
- Counter dc runs 0..DECIM-1 while i_en=1 and wraps to 0.
- A sample strobe occurs in the cycle dc==DECIM-1; i_bit is registered as sample s on that edge.
- DECIM=1 gives a strobe on every enabled cycle.

Repetition-count test (raw samples)
- rc is the run length of identical samples, including the current one.
- First sample after reset/clr: rc=1. Later samples: rc=rc+1 if s equals the previous sample, else rc=1.
- rc saturates at RCT_CUTOFF.
- When rc reaches RCT_CUTOFF, o_rct_fail=1 from the next cycle. It is sticky until i_rst or i_clr.
- While o_rct_fail=1:
  - the FIFO is flushed (o_level=0, o_valid=0) in the same cycle the flag sets;
  - the pair and packer state are cleared;
  - no further words are pushed;
  - sampling and rc continue.

Von Neumann debias
- Samples are paired in order (a, b). The pair phase restarts after reset/clr.
- If a≠b, emit debiased bit a. If a==b, discard the pair.
- At most one debiased bit is produced per two strobes.

Packer
- Bit k of a word is the k-th debiased bit (LSB first).
- After OUT_W bits the word is complete and a push is requested in the same cycle the last bit is shifted in.
- If the push cannot happen, the word is held. Debiased bits arriving while a word is held are dropped; sampling and the RCT continue.
- A held word is pushed on the first cycle the push is allowed, and the packer then restarts at bit 0.

FIFO
- First-word-fall-through: o_data shows the head word whenever o_valid=1. o_data holds its last value when the FIFO is empty.
- Pop occurs when o_valid & i_ready.
- Push is allowed when o_level<FIFO_DEPTH, or when o_level==FIFO_DEPTH and a pop occurs in the same cycle.
- Simultaneous push and pop leaves o_level unchanged.
- A pushed word is visible at the head one cycle later if the FIFO was empty.
- Read and write pointers wrap modulo FIFO_DEPTH.
- The downstream must not rely on o_data being stable while o_valid=0.

Latency
- The last debiased bit of a word is sampled on edge N; the push happens on edge N+1; o_valid rises after edge N+1 if the FIFO was empty.

Reset mid-operation
- Asynchronous i_rst clears everything immediately. A partial word is lost and no stale word ever appears.

Test Plan:
1. Reset, DECIM=1, i_en=1, i_bit pattern 1,0 repeated 16 times (pairs "10") → 16 debiased 1s; words 0xFF, 0xFF pushed; o_level=2; o_valid high 1 cycle after the 8th bit's push edge.
2. i_bit pairs 01,10,00,11,01,01,10,10,01,10 (DECIM=1) → debiased bits 0,1,0,0,1,1,0,1 (the 00/11 pairs are dropped); word 0xB2 (LSB first); no others.
3. i_bit held at 1 for 32 strobes → o_rct_fail=1 the cycle after the 32nd sample; FIFO preloaded with 2 words is flushed (o_level=0); further alternating input is not pushed; i_clr → o_rct_fail=0 and normal operation resumes.
4. i_ready=0, stream alternating pairs until 4 words are buffered plus a 5th complete → o_level=4, 5th word held, subsequent bits dropped; raise i_ready for 1 cycle → pop 1, push the held word same cycle, o_level stays 4; the data order matches generation order.
5. DECIM=4, i_en toggled low for 3 cycles mid-count → dc returns to 0 and the strobe occurs exactly 4 enabled cycles after re-enable; the sample count matches 1 per 4 enabled cycles.
6. Assert i_rst asynchronously mid-word (bit 5 of 8) with FIFO level 3 → o_valid=0, o_level=0, o_rct_fail=0 immediately; after release, the first word output consists only of post-reset bits.
